// File: rtl/dac_serial_ctrl_if.sv
// Sample-pair handshake between the audio mixer (master) and dac_serial_ctrl (slave).
interface dac_serial_ctrl_if;
  logic [11:0] sample_1;
  logic [11:0] sample_2;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_1,
    output sample_2,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_1,
    input  sample_2,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/dac_serial_ctrl.sv
// Dual-channel 12-bit serial DAC driver: buffers one sample pair, shifts it out
// MSB-first on both data lines, then pulses load-enable to update the DAC.
module dac_serial_ctrl #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned INIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  dac_serial_ctrl_if.slave smp,
  output logic             dac_clk,
  output logic             dac_dat1,
  output logic             dac_dat2,
  output logic             dac_leb,
  output logic             dac_rst_b,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);
  typedef enum logic [2:0] {INIT, IDLE, SHIFT, LATCH, GAP} state_e;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [10:0] sh1_q, sh2_q;
  logic [11:0] buf1_q, buf2_q;
  logic        buf_full_q, buf_full_d, ready_q;
  logic        dclk_q, dat1_q, dat2_q, leb_q, rstb_q, busy_q, done_q, urun_q;
  logic        accept, load;

  // Accept and load never coincide: ready is only high while the buffer is empty.
  always_comb begin
    accept = smp.sample_valid && ready_q;
    load   = 1'b0;
    if (buf_full_q && (state_q == IDLE || (state_q == GAP && cnt_q == '0))) begin
      load = 1'b1;
    end
    buf_full_d = buf_full_q;
    if (accept) begin
      buf_full_d = 1'b1;
    end else if (load) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      cnt_q      <= INIT_LAST;
      bit_q      <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      buf1_q     <= '0;
      buf2_q     <= '0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b0;
      dclk_q     <= 1'b0;
      dat1_q     <= 1'b0;
      dat2_q     <= 1'b0;
      leb_q      <= 1'b1;
      rstb_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      ready_q    <= !buf_full_d;
      done_q     <= 1'b0;
      urun_q     <= 1'b0;
      if (accept) begin
        buf1_q <= smp.sample_1;
        buf2_q <= smp.sample_2;
      end
      if (load) begin
        state_q <= SHIFT;
        sh1_q   <= buf1_q[10:0];
        sh2_q   <= buf2_q[10:0];
        dat1_q  <= buf1_q[11];
        dat2_q  <= buf2_q[11];
        bit_q   <= 4'd11;
        cnt_q   <= DIV_LAST;
        dclk_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          INIT: begin
            if (cnt_q == '0) begin
              rstb_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q - 8'd1;
              ready_q <= 1'b0;
            end
          end
          IDLE: ;
          SHIFT: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              cnt_q <= DIV_LAST;
              if (!dclk_q) begin
                dclk_q <= 1'b1;
              end else begin
                // Data only moves on the falling shift-clock edge.
                dclk_q <= 1'b0;
                if (bit_q == '0) begin
                  dat1_q  <= 1'b0;
                  dat2_q  <= 1'b0;
                  leb_q   <= 1'b0;
                  state_q <= LATCH;
                end else begin
                  bit_q  <= bit_q - 4'd1;
                  dat1_q <= sh1_q[10];
                  dat2_q <= sh2_q[10];
                  sh1_q  <= {sh1_q[9:0], 1'b0};
                  sh2_q  <= {sh2_q[9:0], 1'b0};
                end
              end
            end
          end
          LATCH: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              cnt_q   <= DIV_LAST;
              leb_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= GAP;
            end
          end
          GAP: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              urun_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= INIT;
        endcase
      end
    end
  end

  assign smp.sample_ready = ready_q;
  assign dac_clk          = dclk_q;
  assign dac_dat1         = dat1_q;
  assign dac_dat2         = dat2_q;
  assign dac_leb          = leb_q;
  assign dac_rst_b        = rstb_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign underrun         = urun_q;
endmodule

// File: tb/tb_dac_serial_ctrl.sv
// Directed bench for dac_serial_ctrl: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each observed by a small DAC model that shifts on dac_clk rise and latches on dac_leb rise.
module tb_dac_serial_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_serial_ctrl_if ia ();
  dac_serial_ctrl_if ib ();

  logic a_clk, a_d1, a_d2, a_leb, a_rstb, a_busy, a_fd, a_ur;
  logic b_clk, b_d1, b_d2, b_leb, b_rstb, b_busy, b_fd, b_ur;

  dac_serial_ctrl #(.CLK_DIV(2), .INIT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .smp(ia),
    .dac_clk(a_clk), .dac_dat1(a_d1), .dac_dat2(a_d2), .dac_leb(a_leb),
    .dac_rst_b(a_rstb), .busy(a_busy), .frame_done(a_fd), .underrun(a_ur)
  );

  dac_serial_ctrl #(.CLK_DIV(1), .INIT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .smp(ib),
    .dac_clk(b_clk), .dac_dat1(b_d1), .dac_dat2(b_d2), .dac_leb(b_leb),
    .dac_rst_b(b_rstb), .busy(b_busy), .frame_done(b_fd), .underrun(b_ur)
  );

  logic [1:0] m_dclk, m_d1, m_d2, m_leb, m_fd, m_ur;
  assign m_dclk = {b_clk, a_clk};
  assign m_d1   = {b_d1, a_d1};
  assign m_d2   = {b_d2, a_d2};
  assign m_leb  = {b_leb, a_leb};
  assign m_fd   = {b_fd, a_fd};
  assign m_ur   = {b_ur, a_ur};

  logic [1:0]  p_dclk = 2'b00, p_d1 = 2'b00, p_d2 = 2'b00, p_leb = 2'b11;
  logic [11:0] sr1 [2];
  logic [11:0] sr2 [2];
  logic [11:0] lat1 [2];
  logic [11:0] lat2 [2];
  int rises [2], frame_rises [2], first_rise [2], last_rise [2];
  int frames [2], leb_cyc [2], fd_cnt [2], fd_cyc [2], ur_cnt [2], ur_cyc [2];
  int viol [2], hs_cnt [2], hs_cyc [2];
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // Edge-indexed handshake log; cyc counts rising clk edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ia.sample_valid && ia.sample_ready) begin
      hs_cnt[0] <= hs_cnt[0] + 1;
      hs_cyc[0] <= cyc + 1;
    end
    if (ib.sample_valid && ib.sample_ready) begin
      hs_cnt[1] <= hs_cnt[1] + 1;
      hs_cyc[1] <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_dclk[i] && (m_d1[i] != p_d1[i] || m_d2[i] != p_d2[i])) viol[i] <= viol[i] + 1;
      if (rst) begin
        rises[i] <= 0;
      end else if (m_dclk[i] && !p_dclk[i]) begin
        sr1[i] <= {sr1[i][10:0], m_d1[i]};
        sr2[i] <= {sr2[i][10:0], m_d2[i]};
        if (rises[i] == 0) first_rise[i] <= cyc;
        last_rise[i] <= cyc;
        rises[i] <= rises[i] + 1;
      end
      if (m_leb[i] && !p_leb[i]) begin
        lat1[i]        <= sr1[i];
        lat2[i]        <= sr2[i];
        frame_rises[i] <= rises[i];
        rises[i]       <= 0;
        frames[i]      <= frames[i] + 1;
        leb_cyc[i]     <= cyc;
      end
      if (m_fd[i]) begin
        fd_cnt[i] <= fd_cnt[i] + 1;
        fd_cyc[i] <= cyc;
      end
      if (m_ur[i]) begin
        ur_cnt[i] <= ur_cnt[i] + 1;
        ur_cyc[i] <= cyc;
      end
    end
    p_dclk <= m_dclk;
    p_d1   <= m_d1;
    p_d2   <= m_d2;
    p_leb  <= m_leb;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic exp_hi;
    rst = 1'b1;
    ia.sample_1 = 12'h111; ia.sample_2 = 12'h222; ia.sample_valid = 1'b1;
    ib.sample_1 = 12'h000; ib.sample_2 = 12'h000; ib.sample_valid = 1'b0;
    tick(3);
    total_cnt++; if (a_clk !== 1'b0) $display("FAIL rst_dac_clk got %b exp 0", a_clk); else pass_cnt++;
    total_cnt++; if ({a_d1, a_d2} !== 2'b00) $display("FAIL rst_dat got %b exp 00", {a_d1, a_d2}); else pass_cnt++;
    total_cnt++; if (a_leb !== 1'b1) $display("FAIL rst_leb got %b exp 1", a_leb); else pass_cnt++;
    total_cnt++; if (a_rstb !== 1'b0) $display("FAIL rst_rst_b got %b exp 0", a_rstb); else pass_cnt++;
    total_cnt++; if (ia.sample_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", ia.sample_ready); else pass_cnt++;
    total_cnt++; if ({a_busy, a_fd, a_ur} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {a_busy, a_fd, a_ur}); else pass_cnt++;
    total_cnt++; if ({b_leb, b_rstb, b_busy} !== 3'b100) $display("FAIL rst_b_pins got %b exp 100", {b_leb, b_rstb, b_busy}); else pass_cnt++;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      exp_hi = (k == 4);
      total_cnt++; if (a_rstb !== exp_hi) $display("FAIL init_rst_b cyc%0d got %b exp %b", k, a_rstb, exp_hi); else pass_cnt++;
      total_cnt++; if (ia.sample_ready !== exp_hi) $display("FAIL init_ready cyc%0d got %b exp %b", k, ia.sample_ready, exp_hi); else pass_cnt++;
    end
    ia.sample_valid = 1'b0;
    tick(3);
    total_cnt++; if (hs_cnt[0] !== 0) $display("FAIL init_no_accept got %0d exp 0", hs_cnt[0]); else pass_cnt++;
    total_cnt++; if (a_busy !== 1'b0) $display("FAIL init_idle_busy got %b exp 0", a_busy); else pass_cnt++;
  endtask

  task automatic test_single();
    int fr0, ur0, fd0, hs0, k;
    fr0 = frames[0]; ur0 = ur_cnt[0]; fd0 = fd_cnt[0]; hs0 = hs_cnt[0];
    ia.sample_1 = 12'hABC; ia.sample_2 = 12'h123; ia.sample_valid = 1'b1;
    k = 0;
    while (hs_cnt[0] == hs0 && k < 10) begin tick(1); k++; end
    ia.sample_valid = 1'b0;
    k = 0;
    while (frames[0] == fr0 && k < 100) begin tick(1); k++; end
    total_cnt++; if (frames[0] !== fr0 + 1) $display("FAIL single_frame_timeout got %0d exp %0d", frames[0], fr0 + 1); else pass_cnt++;
    tick(4);
    total_cnt++; if (frame_rises[0] !== 12) $display("FAIL single_rises got %0d exp 12", frame_rises[0]); else pass_cnt++;
    total_cnt++; if (lat1[0] !== 12'hABC) $display("FAIL single_lat1 got %h exp abc", lat1[0]); else pass_cnt++;
    total_cnt++; if (lat2[0] !== 12'h123) $display("FAIL single_lat2 got %h exp 123", lat2[0]); else pass_cnt++;
    total_cnt++; if (leb_cyc[0] - hs_cyc[0] !== 51) $display("FAIL single_leb_latency got %0d exp 51", leb_cyc[0] - hs_cyc[0]); else pass_cnt++;
    total_cnt++; if (fd_cyc[0] !== leb_cyc[0]) $display("FAIL single_done_cycle got %0d exp %0d", fd_cyc[0], leb_cyc[0]); else pass_cnt++;
    total_cnt++; if (fd_cnt[0] - fd0 !== 1) $display("FAIL single_done_count got %0d exp 1", fd_cnt[0] - fd0); else pass_cnt++;
    total_cnt++; if (ur_cyc[0] - leb_cyc[0] !== 2) $display("FAIL single_underrun_delay got %0d exp 2", ur_cyc[0] - leb_cyc[0]); else pass_cnt++;
    total_cnt++; if (ur_cnt[0] - ur0 !== 1) $display("FAIL single_underrun_count got %0d exp 1", ur_cnt[0] - ur0); else pass_cnt++;
    total_cnt++; if ({a_busy, ia.sample_ready} !== 2'b01) $display("FAIL single_idle got %b exp 01", {a_busy, ia.sample_ready}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int fr0, ur0, hs0, k, h1, h2, h3, ur3;
    int lc [3];
    logic [11:0] r1 [3];
    logic [11:0] r2 [3];
    fr0 = frames[0]; ur0 = ur_cnt[0]; hs0 = hs_cnt[0];
    h1 = 0; h2 = 0; h3 = 0; ur3 = -1;
    lc[0] = 0; lc[1] = 0; lc[2] = 0;
    ia.sample_1 = 12'hFFF; ia.sample_2 = 12'h000; ia.sample_valid = 1'b1;
    k = 0;
    while (frames[0] < fr0 + 3 && k < 300) begin
      tick(1); k++;
      if (hs_cnt[0] == hs0 + 1 && h1 == 0) begin
        h1 = hs_cyc[0]; ia.sample_1 = 12'h000; ia.sample_2 = 12'hFFF;
      end else if (hs_cnt[0] == hs0 + 2 && h2 == 0) begin
        h2 = hs_cyc[0]; ia.sample_1 = 12'h5A5; ia.sample_2 = 12'hA5A;
      end else if (hs_cnt[0] == hs0 + 3 && h3 == 0) begin
        h3 = hs_cyc[0]; ia.sample_valid = 1'b0;
      end
      for (int f = 0; f < 3; f++) begin
        if (frames[0] == fr0 + f + 1 && lc[f] == 0) begin
          lc[f] = leb_cyc[0]; r1[f] = lat1[0]; r2[f] = lat2[0];
          if (f == 2) ur3 = ur_cnt[0];
        end
      end
    end
    ia.sample_valid = 1'b0;
    tick(4);
    total_cnt++; if (frames[0] !== fr0 + 3) $display("FAIL b2b_frame_timeout got %0d exp %0d", frames[0], fr0 + 3); else pass_cnt++;
    total_cnt++; if (h2 - h1 !== 2) $display("FAIL b2b_second_accept got %0d exp 2", h2 - h1); else pass_cnt++;
    total_cnt++; if (h3 - h1 !== 54) $display("FAIL b2b_third_stall got %0d exp 54", h3 - h1); else pass_cnt++;
    total_cnt++; if (lc[1] - lc[0] !== 52) $display("FAIL b2b_period1 got %0d exp 52", lc[1] - lc[0]); else pass_cnt++;
    total_cnt++; if (lc[2] - lc[1] !== 52) $display("FAIL b2b_period2 got %0d exp 52", lc[2] - lc[1]); else pass_cnt++;
    total_cnt++; if ({r1[0], r2[0]} !== 24'hFFF000) $display("FAIL b2b_frame1 got %h exp fff000", {r1[0], r2[0]}); else pass_cnt++;
    total_cnt++; if ({r1[1], r2[1]} !== 24'h000FFF) $display("FAIL b2b_frame2 got %h exp 000fff", {r1[1], r2[1]}); else pass_cnt++;
    total_cnt++; if ({r1[2], r2[2]} !== 24'h5A5A5A) $display("FAIL b2b_frame3 got %h exp 5a5a5a", {r1[2], r2[2]}); else pass_cnt++;
    total_cnt++; if (ur3 !== ur0) $display("FAIL b2b_no_underrun got %0d exp %0d", ur3, ur0); else pass_cnt++;
  endtask

  task automatic test_clkdiv1();
    int fr0, hs0, ur0, k, h1, h2, lc0, lc1;
    logic [23:0] f0;
    fr0 = frames[1]; hs0 = hs_cnt[1]; ur0 = ur_cnt[1];
    h1 = 0; h2 = 0; lc0 = 0; lc1 = 0; f0 = '0;
    ib.sample_1 = 12'h801; ib.sample_2 = 12'h7FE; ib.sample_valid = 1'b1;
    k = 0;
    while (frames[1] < fr0 + 2 && k < 150) begin
      tick(1); k++;
      if (hs_cnt[1] == hs0 + 1 && h1 == 0) begin
        h1 = hs_cyc[1]; ib.sample_1 = 12'h3C3; ib.sample_2 = 12'hC3C;
      end else if (hs_cnt[1] == hs0 + 2 && h2 == 0) begin
        h2 = hs_cyc[1]; ib.sample_valid = 1'b0;
      end
      if (frames[1] == fr0 + 1 && lc0 == 0) begin lc0 = leb_cyc[1]; f0 = {lat1[1], lat2[1]}; end
      if (frames[1] == fr0 + 2 && lc1 == 0) lc1 = leb_cyc[1];
    end
    ib.sample_valid = 1'b0;
    tick(3);
    total_cnt++; if (frames[1] !== fr0 + 2) $display("FAIL div1_frame_timeout got %0d exp %0d", frames[1], fr0 + 2); else pass_cnt++;
    total_cnt++; if (f0 !== 24'h8017FE) $display("FAIL div1_frame1 got %h exp 8017fe", f0); else pass_cnt++;
    total_cnt++; if ({lat1[1], lat2[1]} !== 24'h3C3C3C) $display("FAIL div1_frame2 got %h exp 3c3c3c", {lat1[1], lat2[1]}); else pass_cnt++;
    total_cnt++; if (lc0 - h1 !== 26) $display("FAIL div1_leb_latency got %0d exp 26", lc0 - h1); else pass_cnt++;
    total_cnt++; if (lc1 - lc0 !== 26) $display("FAIL div1_period got %0d exp 26", lc1 - lc0); else pass_cnt++;
    total_cnt++; if (h2 - h1 !== 2) $display("FAIL div1_second_accept got %0d exp 2", h2 - h1); else pass_cnt++;
    total_cnt++; if (frame_rises[1] !== 12) $display("FAIL div1_rises got %0d exp 12", frame_rises[1]); else pass_cnt++;
    total_cnt++; if (last_rise[1] - first_rise[1] !== 22) $display("FAIL div1_toggle_span got %0d exp 22", last_rise[1] - first_rise[1]); else pass_cnt++;
    total_cnt++; if (ur_cyc[1] - lc1 !== 1) $display("FAIL div1_underrun_delay got %0d exp 1", ur_cyc[1] - lc1); else pass_cnt++;
    total_cnt++; if (ur_cnt[1] - ur0 !== 1) $display("FAIL div1_underrun_count got %0d exp 1", ur_cnt[1] - ur0); else pass_cnt++;
    total_cnt++; if (b_busy !== 1'b0) $display("FAIL div1_idle_busy got %b exp 0", b_busy); else pass_cnt++;
  endtask

  task automatic test_midframe_reset();
    int fr0, fd0, ur0, hs0, k;
    hs0 = hs_cnt[0];
    ia.sample_1 = 12'h3C3; ia.sample_2 = 12'h1E1; ia.sample_valid = 1'b1;
    k = 0;
    while (hs_cnt[0] < hs0 + 2 && k < 20) begin
      tick(1); k++;
      if (hs_cnt[0] == hs0 + 1) begin ia.sample_1 = 12'h777; ia.sample_2 = 12'h888; end
    end
    ia.sample_valid = 1'b0;
    k = 0;
    while (rises[0] < 6 && k < 100) begin tick(1); k++; end
    total_cnt++; if (rises[0] !== 6) $display("FAIL midrst_reach_bit6 got %0d exp 6", rises[0]); else pass_cnt++;
    fr0 = frames[0]; fd0 = fd_cnt[0]; ur0 = ur_cnt[0];
    rst = 1'b1;
    tick(1);
    total_cnt++; if ({a_leb, a_clk, a_d1, a_d2, a_rstb} !== 5'b10000) $display("FAIL midrst_pins got %b exp 10000", {a_leb, a_clk, a_d1, a_d2, a_rstb}); else pass_cnt++;
    total_cnt++; if ({ia.sample_ready, a_busy} !== 2'b00) $display("FAIL midrst_flags got %b exp 00", {ia.sample_ready, a_busy}); else pass_cnt++;
    rst = 1'b0;
    tick(4);
    total_cnt++; if ({a_rstb, ia.sample_ready} !== 2'b11) $display("FAIL midrst_init_exit got %b exp 11", {a_rstb, ia.sample_ready}); else pass_cnt++;
    tick(70);
    total_cnt++; if (frames[0] !== fr0) $display("FAIL midrst_no_stale_frame got %0d exp %0d", frames[0], fr0); else pass_cnt++;
    total_cnt++; if (fd_cnt[0] !== fd0) $display("FAIL midrst_no_done got %0d exp %0d", fd_cnt[0], fd0); else pass_cnt++;
    total_cnt++; if (ur_cnt[0] !== ur0) $display("FAIL midrst_no_underrun got %0d exp %0d", ur_cnt[0], ur0); else pass_cnt++;
    hs0 = hs_cnt[0];
    ia.sample_1 = 12'h555; ia.sample_2 = 12'hAAA; ia.sample_valid = 1'b1;
    k = 0;
    while (hs_cnt[0] == hs0 && k < 10) begin tick(1); k++; end
    ia.sample_valid = 1'b0;
    k = 0;
    while (frames[0] == fr0 && k < 100) begin tick(1); k++; end
    tick(4);
    total_cnt++; if ({lat1[0], lat2[0]} !== 24'h555AAA) $display("FAIL midrst_clean_frame got %h exp 555aaa", {lat1[0], lat2[0]}); else pass_cnt++;
    total_cnt++; if (frame_rises[0] !== 12) $display("FAIL midrst_clean_rises got %0d exp 12", frame_rises[0]); else pass_cnt++;
  endtask

  task automatic test_stability();
    total_cnt++; if (viol[0] !== 0) $display("FAIL stable_data_div2 got %0d exp 0", viol[0]); else pass_cnt++;
    total_cnt++; if (viol[1] !== 0) $display("FAIL stable_data_div1 got %0d exp 0", viol[1]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clkdiv1();
    test_midframe_reset();
    test_stability();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
